// File: rtl/game_ctl.sv
// Tic-tac-toe game-state controller: turns synchronised mouse clicks into board
// moves, alternates turns, and reports win / draw results for the cell painters.
module game_ctl (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        new_game,
    output logic [8:0]  board_x,
    output logic [8:0]  board_o,
    output logic        turn,
    output logic [3:0]  move_cnt,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [7:0]  win_line,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [2:0]  btn_q, btn_d;
    logic [11:0] x1_q, x2_q, y1_q, y2_q;
    logic        click_q, click_d;
    logic [3:0]  cell_q, cell_d;
    logic [8:0]  board_x_q, board_x_d, board_o_q, board_o_d;
    logic        turn_q, turn_d, game_over_q, game_over_d;
    logic [3:0]  move_cnt_q, move_cnt_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  win_line_q, win_line_d;

    logic        col_ok, row_ok, occupied;
    logic [1:0]  col, row;
    logic [8:0]  cell_bit;
    logic [7:0]  lines;

    function automatic logic [7:0] lines_of(input logic [8:0] b);
        lines_of[0] = b[0] & b[1] & b[2];
        lines_of[1] = b[3] & b[4] & b[5];
        lines_of[2] = b[6] & b[7] & b[8];
        lines_of[3] = b[0] & b[3] & b[6];
        lines_of[4] = b[1] & b[4] & b[7];
        lines_of[5] = b[2] & b[5] & b[8];
        lines_of[6] = b[0] & b[4] & b[8];
        lines_of[7] = b[2] & b[4] & b[6];
    endfunction

    // btn_q[0..2] = sync1, sync2, sync3; coordinates ride alongside sync1/sync2.
    always_comb begin
        btn_d = {btn_q[1:0], mouse_left};

        col_ok = 1'b1;
        col    = 2'd0;
        if (x2_q <= 12'd338)                          col = 2'd0;
        else if (x2_q >= 12'd344 && x2_q <= 12'd679)  col = 2'd1;
        else if (x2_q >= 12'd685 && x2_q <= 12'd1023) col = 2'd2;
        else                                          col_ok = 1'b0;

        row_ok = 1'b1;
        row    = 2'd0;
        if (y2_q <= 12'd251)                          row = 2'd0;
        else if (y2_q >= 12'd259 && y2_q <= 12'd507)  row = 2'd1;
        else if (y2_q >= 12'd515 && y2_q <= 12'd767)  row = 2'd2;
        else                                          row_ok = 1'b0;

        click_d = btn_q[1] & ~btn_q[2] & col_ok & row_ok;
        cell_d  = 4'(row) * 4'd3 + 4'(col);
    end

    always_comb begin
        state_d     = state_q;
        board_x_d   = board_x_q;
        board_o_d   = board_o_q;
        turn_d      = turn_q;
        move_cnt_d  = move_cnt_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        win_line_d  = win_line_q;

        cell_bit = 9'd1 << cell_q;
        occupied = |((board_x_q | board_o_q) & cell_bit);
        lines    = lines_of(turn_q ? board_o_q : board_x_q);

        case (state_q)
            PLAY: begin
                if (click_q && !occupied) begin
                    if (turn_q) board_o_d = board_o_q | cell_bit;
                    else        board_x_d = board_x_q | cell_bit;
                    move_cnt_d = move_cnt_q + 4'd1;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (|lines) begin
                    win_line_d  = lines;
                    winner_d    = turn_q ? 2'b10 : 2'b01;
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else if (move_cnt_q == 4'd9) begin
                    winner_d    = 2'b11;
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = PLAY;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = PLAY;
        endcase

        // A new game overrides any move or evaluation in the same cycle.
        if (new_game) begin
            state_d     = PLAY;
            board_x_d   = 9'd0;
            board_o_d   = 9'd0;
            turn_d      = 1'b0;
            move_cnt_d  = 4'd0;
            game_over_d = 1'b0;
            winner_d    = 2'b00;
            win_line_d  = 8'd0;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            btn_q       <= 3'b111;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            click_q     <= 1'b0;
            cell_q      <= '0;
            state_q     <= PLAY;
            board_x_q   <= '0;
            board_o_q   <= '0;
            turn_q      <= 1'b0;
            move_cnt_q  <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            win_line_q  <= '0;
        end else begin
            btn_q       <= btn_d;
            x1_q        <= xpos;
            x2_q        <= x1_q;
            y1_q        <= ypos;
            y2_q        <= y1_q;
            click_q     <= click_d;
            cell_q      <= cell_d;
            state_q     <= state_d;
            board_x_q   <= board_x_d;
            board_o_q   <= board_o_d;
            turn_q      <= turn_d;
            move_cnt_q  <= move_cnt_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            win_line_q  <= win_line_d;
        end
    end

    assign board_x   = board_x_q;
    assign board_o   = board_o_q;
    assign turn      = turn_q;
    assign move_cnt  = move_cnt_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign win_line  = win_line_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: a table of clicks / new-game pulses with
// hand-computed board results, plus timing, priority and reset sequences.
module tb_game_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic        mouse_left, new_game;
    logic [8:0]  board_x, board_o;
    logic        turn, game_over;
    logic [3:0]  move_cnt;
    logic [1:0]  winner, state_dbg;
    logic [7:0]  win_line;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_ng;
        logic [11:0] x, y;
        logic [8:0]  bx, bo;
        logic        trn;
        logic [3:0]  cnt;
        logic        over;
        logic [1:0]  win;
        logic [7:0]  line;
    } vec_t;

    vec_t vecs[$];

    game_ctl dut (
        .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .mouse_left(mouse_left), .new_game(new_game),
        .board_x(board_x), .board_o(board_o), .turn(turn),
        .move_cnt(move_cnt), .game_over(game_over), .winner(winner),
        .win_line(win_line), .state_dbg(state_dbg)
    );

    always #5 pclk = ~pclk;

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("board_x", idx, 16'(board_x), 16'(v.bx));
        chk("board_o", idx, 16'(board_o), 16'(v.bo));
        chk("turn", idx, 16'(turn), 16'(v.trn));
        chk("move_cnt", idx, 16'(move_cnt), 16'(v.cnt));
        chk("game_over", idx, 16'(game_over), 16'(v.over));
        chk("winner", idx, 16'(winner), 16'(v.win));
        chk("win_line", idx, 16'(win_line), 16'(v.line));
        chk("state", idx, 16'(state_dbg), v.over ? 16'd2 : 16'd0);
    endtask

    task automatic click(input logic [11:0] x, input logic [11:0] y);
        @(negedge pclk);
        xpos = x;
        ypos = y;
        mouse_left = 1'b1;
        tick(3);
        mouse_left = 1'b0;
        tick(5);
    endtask

    task automatic pulse_ng();
        @(negedge pclk);
        new_game = 1'b1;
        @(negedge pclk);
        new_game = 1'b0;
    endtask

    function automatic void addc(input logic [11:0] x, input logic [11:0] y,
                                 input logic [8:0] bx, input logic [8:0] bo, input logic trn,
                                 input logic [3:0] cnt, input logic over, input logic [1:0] win,
                                 input logic [7:0] line);
        vec_t v;
        v.is_ng = 1'b0; v.x = x; v.y = y; v.bx = bx; v.bo = bo; v.trn = trn;
        v.cnt = cnt; v.over = over; v.win = win; v.line = line;
        vecs.push_back(v);
    endfunction

    function automatic void add_cell(input int c, input logic [8:0] bx, input logic [8:0] bo,
                                     input logic trn, input logic [3:0] cnt, input logic over,
                                     input logic [1:0] win, input logic [7:0] line);
        logic [11:0] x, y;
        x = (c % 3 == 0) ? 12'd100 : (c % 3 == 1) ? 12'd500 : 12'd900;
        y = (c / 3 == 0) ? 12'd100 : (c / 3 == 1) ? 12'd400 : 12'd700;
        addc(x, y, bx, bo, trn, cnt, over, win, line);
    endfunction

    function automatic void addn();
        vec_t v;
        v.is_ng = 1'b1; v.x = 0; v.y = 0; v.bx = 0; v.bo = 0; v.trn = 0;
        v.cnt = 0; v.over = 0; v.win = 0; v.line = 0;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t r;
        r.is_ng = 1'b1; r.x = 0; r.y = 0; r.bx = 0; r.bo = 0; r.trn = 0;
        r.cnt = 0; r.over = 0; r.win = 0; r.line = 0;

        // Continues after X has taken cell 0 in the hand-written first move.
        add_cell(4, 9'h001, 9'h010, 0, 2, 0, 2'b00, 8'h00);
        add_cell(0, 9'h001, 9'h010, 0, 2, 0, 2'b00, 8'h00);
        addc(12'd340, 12'd100, 9'h001, 9'h010, 0, 2, 0, 2'b00, 8'h00);
        addc(12'd1100, 12'd50, 9'h001, 9'h010, 0, 2, 0, 2'b00, 8'h00);
        addn();
        // X wins on the 0-4-8 diagonal.
        add_cell(0, 9'h001, 9'h000, 1, 1, 0, 2'b00, 8'h00);
        add_cell(1, 9'h001, 9'h002, 0, 2, 0, 2'b00, 8'h00);
        add_cell(4, 9'h011, 9'h002, 1, 3, 0, 2'b00, 8'h00);
        add_cell(2, 9'h011, 9'h006, 0, 4, 0, 2'b00, 8'h00);
        add_cell(8, 9'h111, 9'h006, 0, 5, 1, 2'b01, 8'h40);
        add_cell(3, 9'h111, 9'h006, 0, 5, 1, 2'b01, 8'h40);
        addn();
        // Hit-decode boundaries.
        addc(12'd339, 12'd100, 0, 0, 0, 0, 0, 2'b00, 8'h00);
        addc(12'd1024, 12'd700, 0, 0, 0, 0, 0, 2'b00, 8'h00);
        addc(12'd685, 12'd768, 0, 0, 0, 0, 0, 2'b00, 8'h00);
        addc(12'd100, 12'd252, 0, 0, 0, 0, 0, 2'b00, 8'h00);
        addc(12'd344, 12'd259, 9'h010, 0, 1, 1, 0, 2'b00, 8'h00);
        addc(12'd679, 12'd507, 9'h010, 0, 1, 1, 0, 2'b00, 8'h00);
        addc(12'd685, 12'd515, 9'h010, 9'h100, 0, 2, 0, 2'b00, 8'h00);
        addc(12'd1023, 12'd767, 9'h010, 9'h100, 0, 2, 0, 2'b00, 8'h00);
        addc(12'd338, 12'd251, 9'h011, 9'h100, 1, 3, 0, 2'b00, 8'h00);
        addc(12'd0, 12'd514, 9'h011, 9'h100, 1, 3, 0, 2'b00, 8'h00);
        addc(12'd343, 12'd0, 9'h011, 9'h100, 1, 3, 0, 2'b00, 8'h00);
        addc(12'd680, 12'd0, 9'h011, 9'h100, 1, 3, 0, 2'b00, 8'h00);
        addc(12'd0, 12'd508, 9'h011, 9'h100, 1, 3, 0, 2'b00, 8'h00);
        addc(12'd0, 12'd258, 9'h011, 9'h100, 1, 3, 0, 2'b00, 8'h00);
        addn();
        // Draw: X0 O1 X2 O4 X3 O5 X7 O6 X8.
        add_cell(0, 9'h001, 9'h000, 1, 1, 0, 2'b00, 8'h00);
        add_cell(1, 9'h001, 9'h002, 0, 2, 0, 2'b00, 8'h00);
        add_cell(2, 9'h005, 9'h002, 1, 3, 0, 2'b00, 8'h00);
        add_cell(4, 9'h005, 9'h012, 0, 4, 0, 2'b00, 8'h00);
        add_cell(3, 9'h00d, 9'h012, 1, 5, 0, 2'b00, 8'h00);
        add_cell(5, 9'h00d, 9'h032, 0, 6, 0, 2'b00, 8'h00);
        add_cell(7, 9'h08d, 9'h032, 1, 7, 0, 2'b00, 8'h00);
        add_cell(6, 9'h08d, 9'h072, 0, 8, 0, 2'b00, 8'h00);
        add_cell(8, 9'h18d, 9'h072, 0, 9, 1, 2'b11, 8'h00);
        addn();
        // Ninth-move double-diagonal win beats the draw.
        add_cell(0, 9'h001, 9'h000, 1, 1, 0, 2'b00, 8'h00);
        add_cell(1, 9'h001, 9'h002, 0, 2, 0, 2'b00, 8'h00);
        add_cell(2, 9'h005, 9'h002, 1, 3, 0, 2'b00, 8'h00);
        add_cell(3, 9'h005, 9'h00a, 0, 4, 0, 2'b00, 8'h00);
        add_cell(8, 9'h105, 9'h00a, 1, 5, 0, 2'b00, 8'h00);
        add_cell(5, 9'h105, 9'h02a, 0, 6, 0, 2'b00, 8'h00);
        add_cell(6, 9'h145, 9'h02a, 1, 7, 0, 2'b00, 8'h00);
        add_cell(7, 9'h145, 9'h0aa, 0, 8, 0, 2'b00, 8'h00);
        add_cell(4, 9'h155, 9'h0aa, 0, 9, 1, 2'b01, 8'hc0);
        addn();

        // Reset with the button held: no click may appear.
        rst = 1'b0; mouse_left = 1'b1; new_game = 1'b0; xpos = 12'd100; ypos = 12'd100;
        tick(3);
        chk_all(900, r);
        rst = 1'b1;
        tick(6);
        chk_all(901, r);
        mouse_left = 1'b0;
        tick(4);
        chk_all(902, r);

        // First move with latency checks, E = first posedge after mouse_left rises.
        @(negedge pclk);
        xpos = 12'd100; ypos = 12'd100; mouse_left = 1'b1;
        tick(3);
        chk("e2_board_x", 0, 16'(board_x), 16'h000);
        chk("e2_move_cnt", 0, 16'(move_cnt), 16'd0);
        mouse_left = 1'b0;
        tick(1);
        chk("e3_board_x", 0, 16'(board_x), 16'h001);
        chk("e3_move_cnt", 0, 16'(move_cnt), 16'd1);
        chk("e3_turn", 0, 16'(turn), 16'd0);
        tick(1);
        chk("e4_turn", 0, 16'(turn), 16'd1);
        chk("e4_state", 0, 16'(state_dbg), 16'd0);
        tick(4);

        foreach (vecs[i]) begin
            if (vecs[i].is_ng) pulse_ng();
            else               click(vecs[i].x, vecs[i].y);
            chk_all(i, vecs[i]);
        end

        // new_game in the same cycle the click is seen drops the click.
        @(negedge pclk);
        xpos = 12'd100; ypos = 12'd100; mouse_left = 1'b1;
        tick(3);
        new_game = 1'b1;
        mouse_left = 1'b0;
        tick(1);
        new_game = 1'b0;
        chk_all(950, r);
        tick(4);
        chk_all(951, r);

        // Asynchronous reset mid-game clears without a clock edge.
        click(12'd900, 12'd700);
        chk("pre_rst_board_x", 0, 16'(board_x), 16'h100);
        chk("pre_rst_turn", 0, 16'(turn), 16'd1);
        #2 rst = 1'b0;
        #1;
        chk_all(960, r);
        @(negedge pclk);
        rst = 1'b1;
        tick(2);
        chk_all(961, r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
